// File: rtl/mips_mem_pkg.sv
// Shared constants, state encoding and burst-size helper for the MIPS memory loader.
package mips_mem_pkg;

    localparam logic [1:0] ACC_1W  = 2'b00;
    localparam logic [1:0] ACC_4W  = 2'b01;
    localparam logic [1:0] ACC_8W  = 2'b10;
    localparam logic [1:0] ACC_16W = 2'b11;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_REQ  = 3'd1;
    localparam state_t ST_WR_BEAT = 3'd2;
    localparam state_t ST_RD_REQ  = 3'd3;
    localparam state_t ST_RD_BEAT = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    function automatic logic [1:0] burst_enc(input int len);
        case (len)
            4:       return ACC_4W;
            8:       return ACC_8W;
            16:      return ACC_16W;
            default: return ACC_1W;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_beat_ctr.sv
// Loadable down-counter used for burst beats and read latency; tc flags zero.
module mips_mem_beat_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/mips_mem_loader.sv
// Burst image loader for the MIPS memory; optional readback/compare when
// MEMLD_READBACK_EN is defined (default build writes only).
module mips_mem_loader
    import mips_mem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8002_0000,
    parameter int                WORDS     = 48,
    parameter int                BURST_LEN = 4,
    parameter int                READ_LAT  = 1,
    localparam int               IW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [IW-1:0]     img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        mem_access_size,
    output logic              mem_rw,
    output logic              mem_enable,
    input  logic              mem_busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int            BYTES   = DATA_W / 8;
    localparam int            BW      = $clog2(BURST_LEN) + 1;
    localparam logic [IW-1:0] LAST_W  = IW'(WORDS - 1);
    // Write beats after the request cycle number BURST_LEN-1, so load one less.
    localparam logic [BW-1:0] WR_LOAD = BW'((BURST_LEN > 1) ? BURST_LEN - 2 : 0);
    localparam logic [BW-1:0] RD_LOAD = BW'(BURST_LEN - 1);

    if (WORDS % BURST_LEN != 0) begin : g_chk_words
        $error("mips_mem_loader: WORDS must be a multiple of BURST_LEN");
    end
    if (BURST_LEN != 1 && BURST_LEN != 4 && BURST_LEN != 8 && BURST_LEN != 16) begin : g_chk_bl
        $error("mips_mem_loader: BURST_LEN must be 1, 4, 8 or 16");
    end
    if (DATA_W % 8 != 0 || READ_LAT < 1) begin : g_chk_misc
        $error("mips_mem_loader: DATA_W must be byte-multiple and READ_LAT >= 1");
    end

    function automatic logic [ADDR_W-1:0] word_addr(input logic [IW-1:0] w);
        return BASE_ADDR + ADDR_W'(w) * ADDR_W'(BYTES);
    endfunction

    state_t            state_q, state_d;
    logic [IW-1:0]     w_q, w_d, w_next;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              beat_load, beat_en, beat_tc, wr_last;
    logic [BW-1:0]     beat_val;

    assign w_next = (w_q == LAST_W) ? '0 : w_q + 1'b1;

    mips_mem_beat_ctr #(.W(BW)) u_beat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_load),
        .load_val (beat_val),
        .en       (beat_en),
        .tc       (beat_tc)
    );

`ifdef MEMLD_READBACK_EN
    localparam int LW = $clog2(READ_LAT) + 1;

    logic              gap_q, gap_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic              lat_load, lat_en, lat_tc;

    mips_mem_beat_ctr #(.W(LW)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load),
        .load_val (LW'(READ_LAT - 1)),
        .en       (lat_en),
        .tc       (lat_tc)
    );
`else
    logic unused_dout;
    assign unused_dout = ^mem_dout;
`endif

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        addr_d    = addr_q;
        beat_load = 1'b0;
        beat_en   = 1'b0;
        beat_val  = WR_LOAD;
        wr_last   = 1'b0;
`ifdef MEMLD_READBACK_EN
        gap_d     = gap_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        lat_load  = 1'b0;
        lat_en    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WR_REQ;
                    w_d     = '0;
                    addr_d  = BASE_ADDR;
`ifdef MEMLD_READBACK_EN
                    err_d   = '0;
                    ferr_d  = '0;
`endif
                end
            end
            ST_WR_REQ: begin
                if (!mem_busy) begin
                    w_d       = w_next;
                    beat_load = 1'b1;
                    if (BURST_LEN == 1) wr_last = 1'b1;
                    else                state_d = ST_WR_BEAT;
                end
            end
            ST_WR_BEAT: begin
                w_d     = w_next;
                beat_en = 1'b1;
                wr_last = beat_tc;
            end
`ifdef MEMLD_READBACK_EN
            ST_RD_REQ: begin
                // One idle cycle separates the last write beat from the first read request.
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (!mem_busy) begin
                    state_d   = ST_RD_BEAT;
                    beat_load = 1'b1;
                    beat_val  = RD_LOAD;
                    lat_load  = 1'b1;
                end
            end
            ST_RD_BEAT: begin
                if (lat_tc) begin
                    beat_en = 1'b1;
                    w_d     = w_next;
                    if (mem_dout != img_data) begin
                        if (err_q == '0)       ferr_d = word_addr(w_q);
                        if (err_q != 16'hFFFF) err_d  = err_q + 16'd1;
                    end
                    if (beat_tc) begin
                        if (w_q == LAST_W) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RD_REQ;
                            addr_d  = word_addr(w_next);
                        end
                    end
                end else begin
                    lat_en = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (wr_last) begin
            if (w_q == LAST_W) begin
`ifdef MEMLD_READBACK_EN
                state_d = ST_RD_REQ;
                gap_d   = 1'b1;
                addr_d  = BASE_ADDR;
`else
                state_d = ST_DONE;
`endif
            end else begin
                state_d = ST_WR_REQ;
                addr_d  = word_addr(w_next);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            addr_q  <= addr_d;
        end
    end

    wire in_wr = (state_q == ST_WR_REQ) || (state_q == ST_WR_BEAT);

    assign img_addr        = w_q;
    assign mem_addr        = addr_q;
    assign mem_din         = in_wr ? img_data : '0;
    assign mem_access_size = burst_enc(BURST_LEN);
    assign done            = (state_q == ST_DONE);

`ifdef MEMLD_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q  <= 1'b0;
            err_q  <= '0;
            ferr_q <= '0;
        end else begin
            gap_q  <= gap_d;
            err_q  <= err_d;
            ferr_q <= ferr_d;
        end
    end

    wire in_rd = (state_q == ST_RD_REQ) || (state_q == ST_RD_BEAT);

    assign mem_enable     = in_wr || (state_q == ST_RD_REQ && !gap_q);
    assign mem_rw         = in_rd ? RW_READ : RW_WRITE;
    assign pass           = done && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
`else
    assign mem_enable     = in_wr;
    assign mem_rw         = RW_WRITE;
    assign pass           = 1'b1;
    assign err_count      = '0;
    assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_mips_mem_loader.sv
// Directed bench: two loader instances (4-beat/lat1/48 words and 16-beat/lat3/32 words)
// against a behavioural burst memory; readback checks follow MEMLD_READBACK_EN.
module tb_mips_mem_loader;

    localparam logic [31:0] BASE = 32'h8002_0000;
`ifdef MEMLD_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] busy;
    logic       corrupt;
    int         run_id;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       done_w [2];
    logic       en_w   [2];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int BL  = (g == 0) ? 4 : 16;
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int NW  = (g == 0) ? 48 : 32;

        logic [$clog2(NW)-1:0] img_addr;
        logic [31:0] img_data, mem_addr, mem_din, mem_dout, first_err_addr;
        logic [1:0]  acc;
        logic        rw, en, done, pass;
        logic [15:0] err_count;

        logic [31:0] mem [64];
        int          stamp [64];
        logic [31:0] wr_addrs [128];
        int wr_left = 0, wr_idx = 0, wr_bursts = 0, rd_bursts = 0;
        int rd_cyc = 0, rd_base = 0, rw0_cnt = 0, idx;
        bit rd_act = 0;

        assign img_data  = 32'(img_addr);
        assign done_w[g] = done;
        assign en_w[g]   = en;

        mips_mem_loader #(
            .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE),
            .WORDS(NW), .BURST_LEN(BL), .READ_LAT(LAT)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]),
            .img_addr(img_addr), .img_data(img_data),
            .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
            .mem_access_size(acc), .mem_rw(rw), .mem_enable(en), .mem_busy(busy[g]),
            .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
        );

        function automatic logic [31:0] corr(input int i);
            if (g == 0 && corrupt && i == 17) return 32'h1;
            if (g == 0 && corrupt && i == 34) return 32'h100;
            return 32'h0;
        endfunction

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_left = 0;
                rd_act  = 0;
                mem_dout <= '0;
            end else begin
                if (wr_left > 0) begin
                    if (en && rw && wr_idx < 64) begin
                        mem[wr_idx] = mem_din;
                        stamp[wr_idx] = run_id;
                    end
                    wr_idx++;
                    wr_left--;
                end else if (en && !busy[g]) begin
                    idx = int'((mem_addr - BASE) >> 2);
                    if (rw) begin
                        if (idx >= 0 && idx < 64) begin
                            mem[idx] = mem_din;
                            stamp[idx] = run_id;
                        end
                        wr_idx  = idx + 1;
                        wr_left = BL - 1;
                        if (wr_bursts < 128) wr_addrs[wr_bursts] = mem_addr;
                        wr_bursts++;
                    end else begin
                        rd_act  = 1;
                        rd_cyc  = 0;
                        rd_base = idx;
                        rd_bursts++;
                    end
                end
                if (rd_act) begin
                    rd_cyc++;
                    idx = rd_base + rd_cyc - LAT;
                    if (rd_cyc >= LAT && idx >= 0 && idx < 64) mem_dout <= mem[idx] ^ corr(idx);
                    else mem_dout <= 32'hDEAD_BEEF;
                    if (rd_cyc >= LAT + BL - 1) rd_act = 0;
                end
            end
        end

        always @(negedge clk) if (!rw) rw0_cnt++;
    end

    function automatic int bad_words(input int g, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (g == 0) begin
                if (u[0].mem[i] !== 32'(i) || u[0].stamp[i] != run_id) bad++;
            end else begin
                if (u[1].mem[i] !== 32'(i) || u[1].stamp[i] != run_id) bad++;
            end
        end
        return bad;
    endfunction

    task automatic pulse(input int g);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    // gap = negedges between the last mem_enable sample and the first done sample
    task automatic wait_done(input int g, input string tag, output int gap);
        int since = 0;
        gap = -1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done_w[g]) begin
                gap = since;
                break;
            end
            since = en_w[g] ? 0 : since + 1;
        end
        chk({tag, " done"}, 64'(done_w[g]), 64'd1);
    endtask

    initial begin
        int gap, b0, r0, q0, held;
        bit found;
        rst_n = 1'b0; start = '0; busy = '0; corrupt = 1'b0; run_id = 0;
        repeat (3) @(negedge clk);

        chk("rst en",    64'(u[0].en), 64'd0);
        chk("rst rw",    64'(u[0].rw), 64'd1);
        chk("rst acc",   64'(u[0].acc), 64'd1);
        chk("rst acc16", 64'(u[1].acc), 64'd3);
        chk("rst addr",  64'(u[0].mem_addr), 64'd0);
        chk("rst din",   64'(u[0].mem_din), 64'd0);
        chk("rst img",   64'(u[0].img_addr), 64'd0);
        chk("rst done",  64'(u[0].done), 64'd0);
        chk("rst pass",  64'(u[0].pass), RB ? 64'd0 : 64'd1);
        chk("rst err",   64'(u[0].err_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: clean load of words 0..47
        run_id = 1; b0 = u[0].wr_bursts; r0 = u[0].rd_bursts; q0 = u[0].rw0_cnt;
        pulse(0);
        wait_done(0, "t1", gap);
        chk("t1 wr bursts", 64'(u[0].wr_bursts - b0), 64'd12);
        chk("t1 addr0",  64'(u[0].wr_addrs[b0]), 64'(BASE));
        chk("t1 addr1",  64'(u[0].wr_addrs[b0 + 1]), 64'(BASE + 32'h10));
        chk("t1 addr11", 64'(u[0].wr_addrs[b0 + 11]), 64'(BASE + 32'hB0));
        chk("t1 image",  64'(bad_words(0, 48)), 64'd0);
        chk("t1 rd bursts", 64'(u[0].rd_bursts - r0), RB ? 64'd12 : 64'd0);
        chk("t1 rw0 cycles", 64'(u[0].rw0_cnt - q0), RB ? 64'd61 : 64'd0);
        chk("t1 done gap", 64'(gap), RB ? 64'd4 : 64'd0);
        chk("t1 pass", 64'(u[0].pass), 64'd1);
        chk("t1 err",  64'(u[0].err_count), 64'd0);
        chk("t1 ferr", 64'(u[0].first_err_addr), 64'd0);

        // 2: busy for 7 cycles at the third write request
        run_id = 2; b0 = u[0].wr_bursts;
        pulse(0);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (u[0].en && u[0].mem_addr == BASE + 32'h20 && u[0].wr_left == 0) found = 1;
        end
        chk("t2 req seen", 64'(found), 64'd1);
        busy[0] = 1'b1;
        held = 0;
        repeat (7) begin
            @(negedge clk);
            if (u[0].en && u[0].rw && u[0].mem_addr == BASE + 32'h20) held++;
        end
        busy[0] = 1'b0;
        chk("t2 held", 64'(held), 64'd7);
        wait_done(0, "t2", gap);
        chk("t2 wr bursts", 64'(u[0].wr_bursts - b0), 64'd12);
        chk("t2 addr2", 64'(u[0].wr_addrs[b0 + 2]), 64'(BASE + 32'h20));
        chk("t2 image", 64'(bad_words(0, 48)), 64'd0);

        // 3: corrupted readback at 0x44 and 0x88
        run_id = 3; corrupt = 1'b1;
        pulse(0);
        wait_done(0, "t3", gap);
        chk("t3 err",  64'(u[0].err_count), RB ? 64'd2 : 64'd0);
        chk("t3 ferr", 64'(u[0].first_err_addr), RB ? 64'(BASE + 32'h44) : 64'd0);
        chk("t3 pass", 64'(u[0].pass), RB ? 64'd0 : 64'd1);
        corrupt = 1'b0;

        // 4: reset during beat 2 of the burst at 0x50, then reload
        run_id = 4;
        pulse(0);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (u[0].en && u[0].mem_addr == BASE + 32'h50 && u[0].wr_left == 2) found = 1;
        end
        chk("t4 beat seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4 en async", 64'(u[0].en), 64'd0);
        chk("t4 done rst", 64'(u[0].done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4 idle en",   64'(u[0].en), 64'd0);
        chk("t4 idle done", 64'(u[0].done), 64'd0);
        chk("t4 idle addr", 64'(u[0].mem_addr), 64'd0);
        run_id = 5; b0 = u[0].wr_bursts;
        pulse(0);
        wait_done(0, "t4", gap);
        chk("t4 wr bursts", 64'(u[0].wr_bursts - b0), 64'd12);
        chk("t4 image", 64'(bad_words(0, 48)), 64'd0);
        chk("t4 pass",  64'(u[0].pass), 64'd1);

        // 5: 16-beat bursts, read latency 3, 32 words
        run_id = 6; b0 = u[1].wr_bursts; r0 = u[1].rd_bursts;
        pulse(1);
        wait_done(1, "t5", gap);
        chk("t5 wr bursts", 64'(u[1].wr_bursts - b0), 64'd2);
        chk("t5 addr0", 64'(u[1].wr_addrs[b0]), 64'(BASE));
        chk("t5 addr1", 64'(u[1].wr_addrs[b0 + 1]), 64'(BASE + 32'h40));
        chk("t5 image", 64'(bad_words(1, 32)), 64'd0);
        chk("t5 rd bursts", 64'(u[1].rd_bursts - r0), RB ? 64'd2 : 64'd0);
        chk("t5 done gap", 64'(gap), RB ? 64'd18 : 64'd0);
        chk("t5 pass", 64'(u[1].pass), 64'd1);
        chk("t5 err",  64'(u[1].err_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
